// File: rtl/nonp_fpm.sv
// nonp_fpm: non-pipelined IEEE-754 single-precision multiplier.
// The mantissa product is formed by a 24-step shift-add loop, one multiplier bit per cycle,
// followed by one normalise cycle and one pack cycle.
// The result is truncated, and denormal inputs and results are flushed to zero.
// Every operand class takes the same number of cycles.
module nonp_fpm #(
  parameter int MW   = 23,
  parameter int EW   = 8,
  parameter int BIAS = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MW+EW:0]   ieee1,
  input  logic [MW+EW:0]   ieee2,
  output logic [MW+EW:0]   Fieee,
  output logic             done,
  output logic             busy
);

  localparam int SW = MW + 1;          // significand width with the implicit one
  localparam int PW = 2 * SW;          // full product width
  localparam int XW = EW + 2;          // signed working exponent width
  localparam int CW = $clog2(SW);      // step counter width

  localparam logic [CW-1:0]        CNT_LAST = CW'(SW - 1);
  localparam logic [XW-1:0]        BIAS_X   = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [EW-1:0]        EXP_ONES = '1;
  localparam logic [MW+EW:0]       QNAN     = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         a_q, a_d;
  logic [SW-1:0]         b_q, b_d;
  logic [PW-1:0]         p_q, p_d;
  logic                  sign_q, sign_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic                  zflag_q, zflag_d;
  logic                  iflag_q, iflag_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic [MW+EW:0]        fieee_q, fieee_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [EW-1:0] e1, e2;
  assign e1 = ieee1[MW+EW-1:MW];
  assign e2 = ieee2[MW+EW-1:MW];

  // Next-state and datapath: capture, shift-add steps, normalise, then pack the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    zflag_d = zflag_q;
    iflag_d = iflag_q;
    mant_d  = mant_q;
    fieee_d = fieee_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = {1'b1, ieee1[MW-1:0]};
          b_d     = {1'b1, ieee2[MW-1:0]};
          sign_d  = ieee1[MW+EW] ^ ieee2[MW+EW];
          exp_d   = {2'b00, e1} + {2'b00, e2} - BIAS_X;
          zflag_d = (e1 == '0) || (e2 == '0);
          // NaN inputs share the all-ones exponent, so they fall into the infinity class.
          iflag_d = (e1 == EXP_ONES) || (e2 == EXP_ONES);
          p_d     = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (b_q[cnt_q]) p_d = p_q + (PW'(a_q) << cnt_q);
        // The counter holds at its last value instead of wrapping.
        if (cnt_q == CNT_LAST) state_d = S_NORM;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_NORM: begin
        // The product of two [1,2) significands lies in [1,4): shift by one if it reached 2.
        if (p_q[PW-1]) begin
          mant_d = p_q[PW-2 -: MW];
          exp_d  = exp_q + XW'(1);
        end else begin
          mant_d = p_q[PW-3 -: MW];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (iflag_q && zflag_q)  fieee_d = QNAN;
        else if (iflag_q)        fieee_d = {sign_q, EXP_ONES, {MW{1'b0}}};
        else if (zflag_q)        fieee_d = {sign_q, {(MW+EW){1'b0}}};
        else if (exp_q >= EXP_INF) fieee_d = {sign_q, EXP_ONES, {MW{1'b0}}};
        else if (exp_q <= EXP_ZERO) fieee_d = {sign_q, {(MW+EW){1'b0}}};
        else                     fieee_d = {sign_q, exp_q[EW-1:0], mant_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      zflag_q <= 1'b0;
      iflag_q <= 1'b0;
      mant_q  <= '0;
      fieee_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      zflag_q <= zflag_d;
      iflag_q <= iflag_d;
      mant_q  <= mant_d;
      fieee_q <= fieee_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign Fieee = fieee_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_nonp_fpm.sv
// tb_nonp_fpm: directed self-checking bench for the non-pipelined FP multiplier.
module tb_nonp_fpm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] ieee1;
  logic [31:0] ieee2;
  logic [31:0] Fieee;
  logic        done;
  logic        busy;

  int checks;
  int failures;

  nonp_fpm dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ieee1 (ieee1),
    .ieee2 (ieee2),
    .Fieee (Fieee),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; ieee1 = 32'h0; ieee2 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Fieee !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: Fieee=%h done=%b busy=%b required Fieee=00000000 done=0 busy=0", Fieee, done, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");
  endtask

  // One multiply: checks latency of 26 edges, busy throughout, result, and a single done pulse.
  task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    int lat;
    logic busy_gap;
    @(negedge clk);
    ieee1 = a; ieee2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ieee1 = 32'hDEADBEEF; ieee2 = 32'h12345678;
    lat = 0; busy_gap = 1'b0;
    if (busy !== 1'b1) busy_gap = 1'b1;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lat = n;
      else if (busy !== 1'b1) busy_gap = 1'b1;
    end
    checks++;
    if (lat != 26) begin
      failures++;
      $display("FAIL %s_latency: done after %0d edges required 26", name, lat);
    end
    checks++;
    if (busy_gap) begin
      failures++;
      $display("FAIL %s_busy: busy dropped before done, required high throughout", name);
    end
    checks++;
    if (Fieee !== expv) begin
      failures++;
      $display("FAIL %s_result: Fieee=%h required %h", name, Fieee, expv);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || Fieee !== expv) begin
      failures++;
      $display("FAIL %s_pulse: done=%b Fieee=%h on next cycle required done=0 Fieee=%h", name, done, Fieee, expv);
    end
    $display("op %s: %h x %h -> %h (latency %0d)", name, a, b, Fieee, lat);
  endtask

  // start re-pulsed and operands changed mid-operation, then an asynchronous abort.
  task automatic test_busy_ignore_and_abort();
    int ndone;
    int done_at;
    @(negedge clk);
    ieee1 = 32'h40000000; ieee2 = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0; done_at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) begin
        start = 1'b1; ieee1 = 32'h3F800000; ieee2 = 32'h3F800000;
      end else if (n == 11) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_at == 0) done_at = n;
      end
    end
    checks++;
    if (ndone != 1 || done_at != 26) begin
      failures++;
      $display("FAIL ignore_start: %0d done pulses first at edge %0d, required 1 at edge 26", ndone, done_at);
    end
    checks++;
    if (Fieee !== 32'h40C00000) begin
      failures++;
      $display("FAIL ignore_result: Fieee=%h required 40c00000", Fieee);
    end
    $display("op ignore_busy_start: Fieee=%h done pulses=%0d", Fieee, ndone);

    @(negedge clk);
    ieee1 = 32'h3FC00000; ieee2 = 32'h3FC00000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 12; n++) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (Fieee !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: Fieee=%h done=%b busy=%b required 00000000 0 0", Fieee, done, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || Fieee !== 32'h0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with done/busy after abort, Fieee=%h, required 0 and 00000000", ndone, Fieee);
    end
    $display("op async_abort: Fieee=%h done=%b busy=%b", Fieee, done, busy);
  endtask

  // start held high: three operations issued back to back, 27 cycles apart.
  task automatic test_back_to_back();
    logic [31:0] opa [3];
    logic [31:0] opb [3];
    logic [31:0] res [3];
    int at [3];
    int k;
    opa[0] = 32'h40000000; opb[0] = 32'h40400000; res[0] = 32'h40C00000;
    opa[1] = 32'hBFC00000; opb[1] = 32'h40200000; res[1] = 32'hC0700000;
    opa[2] = 32'h3FC00000; opb[2] = 32'h3FC00000; res[2] = 32'h40100000;
    at[0] = 0; at[1] = 0; at[2] = 0;
    k = 0;
    @(negedge clk);
    ieee1 = opa[0]; ieee2 = opb[0]; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 120 && k < 3; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        at[k] = n;
        checks++;
        if (Fieee !== res[k]) begin
          failures++;
          $display("FAIL b2b_result%0d: Fieee=%h required %h", k, Fieee, res[k]);
        end
        $display("op b2b%0d: %h x %h -> %h at edge %0d", k, opa[k], opb[k], Fieee, n);
        k++;
        if (k < 3) begin
          ieee1 = opa[k]; ieee2 = opb[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (at[0] != 26 || at[1] != 53 || at[2] != 80) begin
      failures++;
      $display("FAIL b2b_spacing: done at edges %0d %0d %0d required 26 53 80", at[0], at[1], at[2]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b after start released, required 0", busy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mul("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000);
    test_mul("neg_mixed",   32'hBFC00000, 32'h40200000, 32'hC0700000);
    test_mul("norm_carry",  32'h3FC00000, 32'h3FC00000, 32'h40100000);
    test_mul("truncate",    32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    test_mul("zero_op",     32'h00000000, 32'hC1200000, 32'h80000000);
    test_mul("underflow",   32'h00800000, 32'h00800000, 32'h00000000);
    test_mul("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000);
    test_mul("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000);
    test_mul("neg_inf",     32'hFF800000, 32'h40000000, 32'hFF800000);
    test_busy_ignore_and_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
